run_ctrl: RTL

- Start/finish sequencer for the single-cycle core.
- Accepts the host req/done handshake and holds the core in reset while idle.
- Runs a fixed init phase, releases PC advance, and detects program end (PC reaches HALT_PC) or a cycle-budget timeout.
- Reports done plus a run-cycle count. Sits between the test host and top_level's PC/flag logic.

---
 rtl/run_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/run_ctrl.sv
// run_ctrl -- start/finish sequencer for the single-cycle core.
//
// Holds the core in reset while idle. On a host start request it runs a fixed
// init phase, releases PC advance, then ends the run on program halt
// (prog_ctr == HALT_PC) or on exhausting the cycle budget. It reports done plus
// the number of RUN cycles spent.
//
// Ports:
//   clk       in   system clock, all state on rising edge
//   reset     in   synchronous active-high reset
//   req       in   host start request (level)
//   abort     in   cancels a run in INIT/RUN/DRAIN
//   prog_ctr  in   [D]  current PC from the PC block
//   core_rst  out  PC/reg-file reset of the core
//   pc_en     out  PC advance enable
//   sc_clr    out  clears the shift/carry flag register
//   done      out  run finished (handshake ack)
//   timeout   out  run ended by budget rather than halt, valid with done
//   cycles    out  [CW] RUN-state cycles of the last/current run
module run_ctrl #(
  parameter int D        = 12,
  parameter int CW       = 16,
  parameter int HALT_PC  = 128,
  parameter int INIT_CYC = 2,
  parameter int MAX_CYC  = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          abort,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          pc_en,
  output logic          sc_clr,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   init_cnt_q, init_cnt_d;
  logic [CW-1:0]   cycles_q, cycles_d;
  logic            timeout_q, timeout_d;

  logic halt_hit, budget_hit, init_last;

  assign halt_hit   = (prog_ctr == D'(HALT_PC));
  // cycles_q still holds the count before this RUN cycle is added
  assign budget_hit = (cycles_q == CW'(MAX_CYC - 1));
  assign init_last  = (init_cnt_q == IW'(INIT_CYC - 1));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------- next state
  // abort outranks halt, halt outranks budget.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_INIT;
      S_INIT: begin
        if (abort)          state_d = S_IDLE;
        else if (init_last) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)           state_d = S_IDLE;
        else if (halt_hit)   state_d = S_DRAIN;
        else if (budget_hit) state_d = S_DONE;
      end
      S_DRAIN: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_DONE;
      end
      S_DONE:  if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- outputs (Moore)
  always_comb begin
    core_rst = 1'b0;
    pc_en    = 1'b0;
    sc_clr   = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE:  core_rst = 1'b1;
      S_INIT: begin
        core_rst = 1'b1;
        sc_clr   = 1'b1;
      end
      S_RUN:   pc_en = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------- run datapath
  always_comb begin
    init_cnt_d = init_cnt_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          // entering INIT: fresh run
          init_cnt_d = '0;
          cycles_d   = '0;
          timeout_d  = 1'b0;
        end
      end
      S_INIT: begin
        if (!init_last) init_cnt_d = init_cnt_q + 1'b1;
      end
      S_RUN: begin
        // every RUN cycle counts, including the halt or abort cycle
        cycles_d = cycles_q + 1'b1;
        if (!abort && !halt_hit && budget_hit) timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt_q <= '0;
      cycles_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      cycles_q   <= cycles_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cycles  = cycles_q;
  assign timeout = timeout_q;

endmodule
